mem_request_arbiter_n: RTL and testbench
========================================

// Module: mem_request_arbiter_n
// PURPOSE
//  N-channel SDRAM request arbiter; successor to the fixed-cache memory request arbiter.
//  Arbitrates NUM_RD burst-read clients (caches, scene retriever) and one single-word writer (scene loader).
//  Drives a word-per-request memory-controller port; round-robin fairness across readers; in-order read return.
// PARAMETERS
//  NUM_RD     4   number of read channels (1..8)
//  ADDR_W     25  word address width (SDRAM)
//  DATA_W     32  data word width
//  MAX_TRANS  16  max words per read burst; TRANS_W = $clog2(MAX_TRANS+1)
// PORTS
//  clk          in   1               system clock
//  rst          in   1               asynchronous, active-high reset
//  readReq      in   NUM_RD          per-channel read request, held until readDone
//  readAddr     in   NUM_RD*ADDR_W   burst start address, stable while readReq
//  readSize     in   NUM_RD*TRANS_W  burst length in words, 1..MAX_TRANS
//  readValid    out  NUM_RD          one-hot data strobe to the granted channel
//  readData     out  DATA_W          shared read data bus
//  readDone     out  NUM_RD          1-cycle pulse with last readValid
//  writeReq     in   1               write request, held until doneWrite
//  writeAddr    in   ADDR_W          write address
//  writeData    in   DATA_W          write data
//  doneWrite    out  1               1-cycle pulse: write accepted by controller
//  mem_req      out  1               controller request
//  mem_we       out  1               1=write, 0=read
//  mem_addr     out  ADDR_W          controller address
//  mem_wdata    out  DATA_W          controller write data
//  mem_gnt      in   1               controller accepts request this cycle
//  mem_rvalid   in   1               read word returned (in order)
//  mem_rdata    in   DATA_W          returned word
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, rr pointer=0, counters 0; in-flight burst discarded (controller reset together).
//  FSM IDLE -> RD_ISSUE | WR; RD_ISSUE -> RD_DRAIN when last word accepted; RD_DRAIN -> IDLE on last rvalid; WR -> IDLE on mem_gnt.
//  Arbitration in IDLE only, registered: request seen cycle N -> mem_req high cycle N+1. No preemption mid-burst.
//  Read: latch channel, addr, size; issue addr, addr+1, ... one per mem_gnt; mem_req held until size words accepted.
//  Issue counter and return counter TRANS_W bits; address increments modulo 2^ADDR_W (wrap allowed, no error).
//  mem_rvalid -> readValid[g]=1, readData=mem_rdata same cycle (combinational pass, zero added latency).
//  readDone[g] pulses with the size-th readValid; channel may drop readReq next cycle; FSM back to IDLE next cycle.
//  readSize=0 is illegal: treated as 1 (simulation assertion fires).
//  rr pointer := granted channel+1 (mod NUM_RD) when burst completes; search starts at pointer.
//  Write: mem_we=1, addr/data from latched inputs; doneWrite pulses cycle mem_gnt seen; FSM to IDLE.
//  readData holds last value when no readValid; mem_addr/mem_wdata don't-care when mem_req=0 (driven 0).
//  mem_rvalid while not in RD_ISSUE/RD_DRAIN: ignored, assertion error.
//  Simultaneous readReq from all channels: each served exactly once before any repeats.
// CONFIGURATION
//  MRA_WRITE_PRIORITY_EN defined: pending writeReq wins every IDLE arbitration over all readers (rr pointer unchanged).
//  Not defined: writer is slot NUM_RD in the round-robin ring (ring size NUM_RD+1).
// STRUCTURE
//  mra_pkg: mra_state_t enum {IDLE,RD_ISSUE,RD_DRAIN,WR}; default parameter constants; TRANS_W function.
//  Sub-module rr_arbiter #(N): req vector + pointer in -> one-hot grant + valid out, purely combinational.
//  FSM, counters, latches, output muxing in this module.
// TESTING
//  Single read ch0 addr=0x100 size=4, mem_gnt always 1, rvalid 3 cycles later -> addrs 0x100..0x103, 4 readValid[0], readDone[0] on 4th.
//  All 4 channels request size=2 simultaneously, pointer=0 -> grant order 0,1,2,3, then ch0 again if still requesting.
//  Write 0xDEADBEEF @0x5 during ch1 burst -> write waits for burst end; doneWrite 1 pulse; with MRA_WRITE_PRIORITY_EN wins over pending ch2.
//  mem_gnt toggling 1,0,1,0 with size=MAX_TRANS=16 -> exactly 16 accepted requests, addresses contiguous, no duplicates.
//  Burst at addr=2^25-2 size=4 -> addresses 0x1FFFFFE,0x1FFFFFF,0x0,0x1.
//  Assert rst mid-RD_DRAIN -> all outputs 0 immediately, next request after release issues from IDLE with pointer 0.

Source files
------------

// File: rtl/mra_pkg.sv
// mra_pkg -- shared types and constants for the N-channel memory request arbiter.
//   mra_state_t : arbiter FSM states
//   MRA_*       : default parameter values
//   trans_w()   : width of a burst-length / word counter for a given MAX_TRANS
//   idx_w()     : width of an index into an n-entry vector (at least 1)
package mra_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_ISSUE = 2'd1,
      RD_DRAIN = 2'd2,
      WR       = 2'd3
   } mra_state_t;

   localparam int MRA_NUM_RD    = 4;
   localparam int MRA_ADDR_W    = 25;
   localparam int MRA_DATA_W    = 32;
   localparam int MRA_MAX_TRANS = 16;

   // Counter must be able to hold MAX_TRANS itself, hence +1.
   function automatic int trans_w(input int max_trans);
      return $clog2(max_trans + 1);
   endfunction

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter -- purely combinational round-robin pick.
//   i_req   [N-1:0]  request vector
//   i_ptr   [PW-1:0] highest-priority slot (must be < N)
//   o_gnt   [N-1:0]  one-hot grant (zero when no request)
//   o_valid          any request present
// The search starts at i_ptr and wraps: requests at or above the pointer
// are tried first, then the lowest request below it.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  i_req,
   input  logic [PW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic          o_valid
);

   logic [N-1:0] w_mask;
   logic [N-1:0] w_hi;
   logic         w_found;

   always_comb begin
      w_mask  = '0;
      w_hi    = '0;
      w_found = 1'b0;
      o_gnt   = '0;
      o_valid = |i_req;
      for (int j = 0; j < N; j++) begin
         w_mask[j] = (j >= int'(i_ptr));
      end
      w_hi = i_req & w_mask;
      for (int j = 0; j < N; j++) begin
         if (!w_found && w_hi[j]) begin
            o_gnt[j] = 1'b1;
            w_found  = 1'b1;
         end
      end
      // Nothing at/above the pointer: wrap to the lowest request.
      for (int j = 0; j < N; j++) begin
         if (!w_found && i_req[j]) begin
            o_gnt[j] = 1'b1;
            w_found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_request_arbiter_n.sv
// mem_request_arbiter_n -- arbitrates NUM_RD burst-read clients and one
// single-word writer onto a word-per-request SDRAM controller port.
//   clk, rst                     clock, asynchronous active-high reset
//   readReq/readAddr/readSize    per-channel burst request (held until readDone)
//   readValid/readData/readDone  one-hot data strobe, shared data bus, last-word pulse
//   writeReq/writeAddr/writeData single-word write request (held until doneWrite)
//   doneWrite                    pulse when the controller accepts the write
//   mem_req/mem_we/mem_addr/mem_wdata  controller request side
//   mem_gnt/mem_rvalid/mem_rdata       controller accept and in-order read return
// Build option MRA_WRITE_PRIORITY_EN: when defined, a pending write wins every
// IDLE arbitration and the reader pointer is left alone; otherwise the writer
// is slot NUM_RD of a NUM_RD+1 round-robin ring.
module mem_request_arbiter_n
   import mra_pkg::*;
#(
   parameter  int NUM_RD    = MRA_NUM_RD,
   parameter  int ADDR_W    = MRA_ADDR_W,
   parameter  int DATA_W    = MRA_DATA_W,
   parameter  int MAX_TRANS = MRA_MAX_TRANS,
   localparam int TRANS_W   = trans_w(MAX_TRANS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_RD-1:0]           readReq,
   input  logic [NUM_RD*ADDR_W-1:0]    readAddr,
   input  logic [NUM_RD*TRANS_W-1:0]   readSize,
   output logic [NUM_RD-1:0]           readValid,
   output logic [DATA_W-1:0]           readData,
   output logic [NUM_RD-1:0]           readDone,
   input  logic                        writeReq,
   input  logic [ADDR_W-1:0]           writeAddr,
   input  logic [DATA_W-1:0]           writeData,
   output logic                        doneWrite,
   output logic                        mem_req,
   output logic                        mem_we,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_wdata,
   input  logic                        mem_gnt,
   input  logic                        mem_rvalid,
   input  logic [DATA_W-1:0]           mem_rdata
);

   localparam int CH_W = idx_w(NUM_RD);
`ifdef MRA_WRITE_PRIORITY_EN
   localparam int RING = NUM_RD;
`else
   localparam int RING = NUM_RD + 1;
`endif
   localparam int PTR_W = idx_w(RING);

   mra_state_t          r_state;
   logic [CH_W-1:0]     r_ch;
   logic [PTR_W-1:0]    r_ptr;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_rdata;
   logic [TRANS_W-1:0]  r_size;
   logic [TRANS_W-1:0]  r_icnt;
   logic [TRANS_W-1:0]  r_rcnt;
   logic                r_mem_req;
   logic                r_we;

   logic [RING-1:0]     w_ring_req;
   logic [RING-1:0]     w_ring_gnt;
   logic                w_ring_vld;
   logic                w_wr_win;
   logic                w_rd_win;
   logic [CH_W-1:0]     w_gnt_ch;
   logic [ADDR_W-1:0]   w_gnt_addr;
   logic [TRANS_W-1:0]  w_gnt_size;
   logic [TRANS_W-1:0]  w_size_eff;
   logic [NUM_RD-1:0]   w_ch_oh;
   logic [PTR_W-1:0]    w_ptr_nxt;
   logic                w_in_rd;
   logic                w_rv;
   logic                w_last_iss;
   logic                w_last_ret;

`ifdef MRA_WRITE_PRIORITY_EN
   assign w_ring_req = readReq;
`else
   assign w_ring_req = {writeReq, readReq};
`endif

   rr_arbiter #(.N(RING), .PW(PTR_W)) u_rr (
      .i_req   (w_ring_req),
      .i_ptr   (r_ptr),
      .o_gnt   (w_ring_gnt),
      .o_valid (w_ring_vld)
   );

   // Decode the winning reader and pick up its burst parameters.
   always_comb begin
      w_gnt_ch   = '0;
      w_gnt_addr = '0;
      w_gnt_size = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         if (w_ring_gnt[i]) begin
            w_gnt_ch   = CH_W'(i);
            w_gnt_addr = readAddr[i*ADDR_W +: ADDR_W];
            w_gnt_size = readSize[i*TRANS_W +: TRANS_W];
         end
      end
`ifdef MRA_WRITE_PRIORITY_EN
      w_wr_win = writeReq;
`else
      w_wr_win = w_ring_gnt[NUM_RD];
`endif
      w_rd_win   = w_ring_vld && !w_wr_win;
      // A zero-length burst is illegal; serve it as a single word.
      w_size_eff = (w_gnt_size == '0) ? TRANS_W'(1) : w_gnt_size;
   end

   always_comb begin
      w_ch_oh = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         w_ch_oh[i] = (r_ch == CH_W'(i));
      end
      w_ptr_nxt = PTR_W'(r_ch) + PTR_W'(1);
      if (int'(r_ch) == RING - 1) w_ptr_nxt = '0;
   end

   assign w_in_rd    = (r_state == RD_ISSUE) || (r_state == RD_DRAIN);
   // Returns outside a read burst are dropped on the floor.
   assign w_rv       = w_in_rd && mem_rvalid;
   assign w_last_iss = (r_state == RD_ISSUE) && mem_gnt && (r_icnt == r_size - TRANS_W'(1));
   assign w_last_ret = w_rv && (r_rcnt == r_size - TRANS_W'(1));

   // Read return is a straight pass-through so it costs no latency.
   assign readValid = w_rv ? w_ch_oh : '0;
   assign readDone  = w_last_ret ? w_ch_oh : '0;
   assign readData  = w_rv ? mem_rdata : r_rdata;
   assign doneWrite = (r_state == WR) && mem_gnt;
   assign mem_req   = r_mem_req;
   assign mem_we    = r_we;
   assign mem_addr  = r_mem_req ? r_addr : '0;
   assign mem_wdata = r_we ? r_wdata : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_ch      <= '0;
         r_ptr     <= '0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_rdata   <= '0;
         r_size    <= '0;
         r_icnt    <= '0;
         r_rcnt    <= '0;
         r_mem_req <= 1'b0;
         r_we      <= 1'b0;
      end else begin
         if (w_rv) r_rdata <= mem_rdata;
         case (r_state)
            IDLE: begin
               if (w_wr_win) begin
                  r_state   <= WR;
                  r_mem_req <= 1'b1;
                  r_we      <= 1'b1;
                  r_addr    <= writeAddr;
                  r_wdata   <= writeData;
               end else if (w_rd_win) begin
                  r_state   <= RD_ISSUE;
                  r_mem_req <= 1'b1;
                  r_ch      <= w_gnt_ch;
                  r_addr    <= w_gnt_addr;
                  r_size    <= w_size_eff;
                  r_icnt    <= '0;
                  r_rcnt    <= '0;
               end
            end
            RD_ISSUE: begin
               if (mem_gnt) begin
                  // Address wraps modulo 2^ADDR_W by design.
                  r_addr <= r_addr + ADDR_W'(1);
                  r_icnt <= r_icnt + TRANS_W'(1);
                  if (w_last_iss) begin
                     r_mem_req <= 1'b0;
                     r_state   <= RD_DRAIN;
                  end
               end
               if (w_rv) r_rcnt <= r_rcnt + TRANS_W'(1);
            end
            RD_DRAIN: begin
               if (w_rv) r_rcnt <= r_rcnt + TRANS_W'(1);
               if (w_last_ret) begin
                  r_state <= IDLE;
                  r_ptr   <= w_ptr_nxt;
               end
            end
            WR: begin
               if (mem_gnt) begin
                  r_state   <= IDLE;
                  r_mem_req <= 1'b0;
                  r_we      <= 1'b0;
`ifndef MRA_WRITE_PRIORITY_EN
                  // Writer is the last ring slot; the next search wraps to 0.
                  r_ptr     <= '0;
`endif
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   a_size_nonzero: assert property (@(posedge clk) disable iff (rst)
      (r_state == IDLE && w_rd_win) |-> (w_gnt_size != '0));

   a_rvalid_in_read: assert property (@(posedge clk) disable iff (rst)
      mem_rvalid |-> w_in_rd);

endmodule

// File: tb/tb_mem_request_arbiter_n.sv
module tb_mem_request_arbiter_n;

   localparam int NR = 4;
   localparam int AW = 25;
   localparam int DW = 32;
   localparam int TW = 5;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic [NR-1:0]      readReq;
   logic [NR*AW-1:0]   readAddr;
   logic [NR*TW-1:0]   readSize;
   logic [NR-1:0]      readValid;
   logic [DW-1:0]      readData;
   logic [NR-1:0]      readDone;
   logic               writeReq;
   logic [AW-1:0]      writeAddr;
   logic [DW-1:0]      writeData;
   logic               doneWrite;
   logic               mem_req, mem_we;
   logic [AW-1:0]      mem_addr;
   logic [DW-1:0]      mem_wdata;
   logic               mem_gnt, mem_rvalid;
   logic [DW-1:0]      mem_rdata;

   always #5 clk = ~clk;

   mem_request_arbiter_n dut (
      .clk(clk), .rst(rst),
      .readReq(readReq), .readAddr(readAddr), .readSize(readSize),
      .readValid(readValid), .readData(readData), .readDone(readDone),
      .writeReq(writeReq), .writeAddr(writeAddr), .writeData(writeData),
      .doneWrite(doneWrite),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } req_t;
   typedef struct { int ch; logic [DW-1:0] data; logic done; } rd_t;
   typedef struct { int due; logic [DW-1:0] data; } ret_t;

   req_t exp_req[$];
   rd_t  exp_rd[$];
   ret_t ret_q[$];

   int want_rd[NR];
   int served_rd[NR];
   int want_wr, served_wr;
   int cyc, gnt_mode, acc_cnt, dw_cnt;
   int errors, checks;

   function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
      return 32'hA5000000 ^ {7'd0, a};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Controller model, client request driver and scoreboard monitor.
   initial begin
      readReq = '0; writeReq = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      cyc = 0; acc_cnt = 0; dw_cnt = 0;
      forever begin
         @(posedge clk); #1;
         cyc++;
         mem_rvalid = 1'b0;
         if (rst) begin
            ret_q.delete();
            for (int i = 0; i < NR; i++) served_rd[i] = want_rd[i];
            served_wr = want_wr;
         end else if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = ret_q[0].data;
            void'(ret_q.pop_front());
         end
         mem_gnt = (gnt_mode == 0) ? 1'b1 : cyc[0];
         for (int i = 0; i < NR; i++) readReq[i] = (want_rd[i] != served_rd[i]);
         writeReq = (want_wr != served_wr);

         @(negedge clk);
         if (!rst) begin
            if (mem_req && mem_gnt) begin
               acc_cnt++;
               if (exp_req.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_req: got addr %0h we %0b, expected none", mem_addr, mem_we);
               end else begin
                  req_t e;
                  e = exp_req.pop_front();
                  chk("req_we", 64'(mem_we), 64'(e.we));
                  chk("req_addr", 64'(mem_addr), 64'(e.addr));
                  if (e.we) begin
                     chk("req_wdata", 64'(mem_wdata), 64'(e.wdata));
                     chk("doneWrite_on_gnt", 64'(doneWrite), 64'(1));
                  end
               end
               if (!mem_we) ret_q.push_back('{due: cyc + 3, data: mdata(mem_addr)});
            end
            if (doneWrite) begin
               dw_cnt++;
               served_wr++;
            end
            if (readValid != '0) begin
               if (exp_rd.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_readValid: got %0h, expected none", readValid);
               end else begin
                  rd_t r;
                  r = exp_rd.pop_front();
                  chk("rd_valid", 64'(readValid), 64'(1) << r.ch);
                  chk("rd_data", 64'(readData), 64'(r.data));
                  chk("rd_done", 64'(readDone), r.done ? (64'(1) << r.ch) : 64'(0));
               end
            end else if (readDone != '0) begin
               checks++; errors++;
               $display("FAIL stray_readDone: got %0h expected 0", readDone);
            end
            for (int i = 0; i < NR; i++) if (readDone[i]) served_rd[i]++;
         end
      end
   end

   task automatic exp_word(input int ch, input logic [AW-1:0] a, input logic done);
      exp_req.push_back('{we: 1'b0, addr: a, wdata: '0});
      exp_rd.push_back('{ch: ch, data: mdata(a), done: done});
   endtask

   task automatic exp_burst(input int ch, input logic [AW-1:0] a, input int n);
      for (int k = 0; k < n; k++) exp_word(ch, a + AW'(k), k == n - 1);
   endtask

   task automatic rd_req(input int ch, input logic [AW-1:0] a, input int sz);
      readAddr[ch*AW +: AW] = a;
      readSize[ch*TW +: TW] = TW'(sz);
      want_rd[ch]++;
   endtask

   // Called at a negedge; asserts reset mid-cycle and checks outputs at once.
   task automatic do_reset(input string nm);
      #2 rst = 1'b1;
      #1;
      chk({nm, "_mem_req"},   64'(mem_req),   64'(0));
      chk({nm, "_mem_we"},    64'(mem_we),    64'(0));
      chk({nm, "_mem_addr"},  64'(mem_addr),  64'(0));
      chk({nm, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
      chk({nm, "_readValid"}, 64'(readValid), 64'(0));
      chk({nm, "_readDone"},  64'(readDone),  64'(0));
      chk({nm, "_readData"},  64'(readData),  64'(0));
      chk({nm, "_doneWrite"}, 64'(doneWrite), 64'(0));
      repeat (2) @(negedge clk);
      exp_req.delete();
      exp_rd.delete();
      #1 rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_quiet(input string nm, input int limit);
      int  n;
      bit  busy;
      n = 0;
      busy = 1'b1;
      while (busy && n < limit) begin
         @(negedge clk);
         n++;
         busy = (exp_req.size() != 0) || (exp_rd.size() != 0) || (want_wr != served_wr);
         for (int i = 0; i < NR; i++) if (want_rd[i] != served_rd[i]) busy = 1'b1;
      end
      checks++;
      if (busy) begin
         errors++;
         $display("FAIL %s_timeout: got %0d pending req/%0d pending rd after %0d cycles, expected 0",
                  nm, exp_req.size(), exp_rd.size(), limit);
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int a0, d0, n;
      errors = 0; checks = 0; gnt_mode = 0;
      readAddr = '0; readSize = '0; writeAddr = '0; writeData = '0;
      want_wr = 0; served_wr = 0;
      for (int i = 0; i < NR; i++) begin want_rd[i] = 0; served_rd[i] = 0; end

      // T1: single burst, registered arbitration latency, readData hold.
      @(negedge clk);
      do_reset("rst0");
      exp_word(0, 25'h100, 1'b0);
      exp_word(0, 25'h101, 1'b0);
      exp_word(0, 25'h102, 1'b0);
      exp_word(0, 25'h103, 1'b1);
      rd_req(0, 25'h100, 4);
      @(negedge clk);
      chk("t1_mem_req_not_yet", 64'(mem_req), 64'(0));
      @(negedge clk);
      chk("t1_mem_req_next_cycle", 64'(mem_req), 64'(1));
      wait_quiet("t1", 60);
      chk("t1_readData_hold", 64'(readData), 64'(32'hA5000103));

      // T2: all four channels at once, ch0 keeps requesting for a second burst.
      do_reset("rst1");
      exp_burst(0, 25'h200, 2);
      exp_burst(1, 25'h300, 2);
      exp_burst(2, 25'h400, 2);
      exp_burst(3, 25'h500, 2);
      exp_burst(0, 25'h200, 2);
      rd_req(0, 25'h200, 2);
      rd_req(0, 25'h200, 2);
      rd_req(1, 25'h300, 2);
      rd_req(2, 25'h400, 2);
      rd_req(3, 25'h500, 2);
      wait_quiet("t2", 120);

      // T3: write and ch2 arrive during a ch1 burst.
      do_reset("rst2");
      d0 = dw_cnt;
      exp_burst(1, 25'h40, 4);
`ifdef MRA_WRITE_PRIORITY_EN
      exp_req.push_back('{we: 1'b1, addr: 25'h5, wdata: 32'hDEADBEEF});
      exp_burst(2, 25'h80, 2);
`else
      exp_burst(2, 25'h80, 2);
      exp_req.push_back('{we: 1'b1, addr: 25'h5, wdata: 32'hDEADBEEF});
`endif
      rd_req(1, 25'h40, 4);
      repeat (2) @(negedge clk);
      writeAddr = 25'h5;
      writeData = 32'hDEADBEEF;
      rd_req(2, 25'h80, 2);
      want_wr++;
      wait_quiet("t3", 100);
      chk("t3_doneWrite_pulses", 64'(dw_cnt - d0), 64'(1));

      // T4: max-length burst with a toggling grant.
      do_reset("rst3");
      gnt_mode = 1;
      a0 = acc_cnt;
      exp_burst(3, 25'h1000, 16);
      rd_req(3, 25'h1000, 16);
      wait_quiet("t4", 200);
      chk("t4_accepted_count", 64'(acc_cnt - a0), 64'(16));
      gnt_mode = 0;

      // T5: address wrap at the top of the SDRAM space.
      do_reset("rst4");
      exp_word(1, 25'h1FFFFFE, 1'b0);
      exp_word(1, 25'h1FFFFFF, 1'b0);
      exp_word(1, 25'h0000000, 1'b0);
      exp_word(1, 25'h0000001, 1'b1);
      rd_req(1, 25'h1FFFFFE, 4);
      wait_quiet("t5", 60);

      // T6: reset during RD_DRAIN, pointer must restart at 0.
      do_reset("rst5");
      exp_burst(2, 25'h600, 2);
      rd_req(2, 25'h600, 2);
      wait_quiet("t6a", 60);
      exp_burst(2, 25'h600, 4);
      rd_req(2, 25'h600, 4);
      n = 0;
      while (n < 60 && !(exp_req.size() == 0 && exp_rd.size() <= 2)) begin
         @(negedge clk);
         n++;
      end
      chk("t6_reached_drain", 64'(n < 60), 64'(1));
      chk("t6_all_issued", 64'(exp_req.size()), 64'(0));
      do_reset("rst_drain");
      exp_burst(1, 25'h700, 1);
      exp_burst(3, 25'h800, 1);
      rd_req(1, 25'h700, 1);
      rd_req(3, 25'h800, 1);
      wait_quiet("t6b", 60);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
